// File: rtl/yutorina_pbus_if.sv
// Bus bundle for the yutorina peripheral bus. "master" is the surrounding system
// (bus masters plus slave devices); "slave" is the arbiter/mux that serves them.
interface yutorina_pbus_if #(
  parameter int M_NUM  = 4,
  parameter int S_NUM  = 8,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic [M_NUM-1:0]        m_req_;
  logic [M_NUM*ADDR_W-1:0] m_addr;
  logic [M_NUM-1:0]        m_as_;
  logic [M_NUM-1:0]        m_rw;
  logic [M_NUM*DATA_W-1:0] m_w_data;
  logic [M_NUM-1:0]        m_grnt_;
  logic [DATA_W-1:0]       m_r_data;
  logic                    m_rdy_;
  logic                    m_err;
  logic [ADDR_W-1:0]       s_addr;
  logic                    s_as_;
  logic                    s_rw;
  logic [DATA_W-1:0]       s_w_data;
  logic [S_NUM*DATA_W-1:0] s_r_data;
  logic [S_NUM-1:0]        s_rdy_;
  logic [S_NUM-1:0]        s_cs_;

  modport master (
    output m_req_, m_addr, m_as_, m_rw, m_w_data, s_r_data, s_rdy_,
    input  m_grnt_, m_r_data, m_rdy_, m_err, s_addr, s_as_, s_rw, s_w_data, s_cs_
  );

  modport slave (
    input  m_req_, m_addr, m_as_, m_rw, m_w_data, s_r_data, s_rdy_,
    output m_grnt_, m_r_data, m_rdy_, m_err, s_addr, s_as_, s_rw, s_w_data, s_cs_
  );
endinterface

// File: rtl/yutorina_pbus.sv
// Round-robin multi-master peripheral bus: owner arbitration, request mux,
// address-decoded slave select and a wait counter that raises a bus error.
module yutorina_pbus #(
  parameter int M_NUM   = 4,
  parameter int S_NUM   = 8,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  yutorina_pbus_if.slave   bus
);
  localparam int MW = $clog2(M_NUM);
  localparam int SW = $clog2(S_NUM);

  logic [MW-1:0]     r_owner;
  logic [MW-1:0]     w_next_owner;
  logic [7:0]        r_wait;
  logic [7:0]        w_wait_next;
  logic              w_owner_req_;
  logic [ADDR_W-1:0] w_addr;
  logic              w_as_;
  logic [SW-1:0]     w_sel;
  logic              w_sel_rdy_;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_timeout;

  // Request mux: everything the slave side sees comes from the current owner.
  always_comb begin
    w_owner_req_   = 1'b1;
    w_addr         = '0;
    w_as_          = 1'b1;
    bus.s_rw       = 1'b0;
    bus.s_w_data   = '0;
    bus.m_grnt_    = '1;
    for (int j = 0; j < M_NUM; j++) begin
      if (r_owner == MW'(j)) begin
        w_owner_req_   = bus.m_req_[j];
        w_addr         = bus.m_addr[j*ADDR_W +: ADDR_W];
        w_as_          = bus.m_as_[j];
        bus.s_rw       = bus.m_rw[j];
        bus.s_w_data   = bus.m_w_data[j*DATA_W +: DATA_W];
        bus.m_grnt_[j] = 1'b0;
      end
    end
  end

  assign bus.s_addr = w_addr;
  assign bus.s_as_  = w_as_;

  // Round-robin: the requester at the smallest circular distance after the owner wins.
  always_comb begin : arb
    int d;
    int best;
    d            = 0;
    best         = M_NUM;
    w_next_owner = r_owner;
    if (w_owner_req_) begin
      for (int j = 0; j < M_NUM; j++) begin
        d = j - int'(r_owner);
        if (d <= 0) d = d + M_NUM;
        if (!bus.m_req_[j] && d < best) begin
          best         = d;
          w_next_owner = MW'(j);
        end
      end
    end
  end

  assign w_sel = w_addr[ADDR_W-1 -: SW];

  always_comb begin
    w_sel_rdy_ = 1'b1;
    w_sel_data = '0;
    for (int k = 0; k < S_NUM; k++) begin
      if (w_sel == SW'(k)) begin
        w_sel_rdy_ = bus.s_rdy_[k];
        w_sel_data = bus.s_r_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // A slave answering in the timeout cycle wins over the error.
  assign w_timeout = (r_wait == 8'(TIMEOUT)) && w_sel_rdy_;

  always_comb begin
    bus.m_err    = w_timeout;
    bus.m_rdy_   = w_timeout ? 1'b0 : w_sel_rdy_;
    bus.m_r_data = w_timeout ? '0 : w_sel_data;
    bus.s_cs_    = '1;
    for (int k = 0; k < S_NUM; k++) begin
      if (!w_timeout && w_sel == SW'(k)) bus.s_cs_[k] = 1'b0;
    end
  end

  always_comb begin
    if (w_next_owner != r_owner || w_as_ || !w_sel_rdy_ || w_timeout)
      w_wait_next = 8'd0;
    else
      w_wait_next = r_wait + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= '0;
      r_wait  <= 8'd0;
    end else begin
      r_owner <= w_next_owner;
      r_wait  <= w_wait_next;
    end
  end
endmodule

// File: tb/tb_yutorina_pbus.sv
// Bench for yutorina_pbus: two configurations (4x8, TIMEOUT 15 and 2x2, TIMEOUT 5)
// driven together and checked every cycle against a behavioural model.
module tb_yutorina_pbus;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  yutorina_pbus_if #(.M_NUM(4), .S_NUM(8), .ADDR_W(30), .DATA_W(32)) ifa ();
  yutorina_pbus_if #(.M_NUM(2), .S_NUM(2), .ADDR_W(30), .DATA_W(32)) ifb ();

  yutorina_pbus #(.M_NUM(4), .S_NUM(8), .ADDR_W(30), .DATA_W(32), .TIMEOUT(15))
    ua (.clk(clk), .rst(rst), .bus(ifa));
  yutorina_pbus #(.M_NUM(2), .S_NUM(2), .ADDR_W(30), .DATA_W(32), .TIMEOUT(5))
    ub (.clk(clk), .rst(rst), .bus(ifb));

  logic [7:0]  req_n [2];
  logic [7:0]  as_n  [2];
  logic [7:0]  rw    [2];
  logic [7:0]  srdy_n[2];
  logic [29:0] maddr [2][8];
  logic [31:0] wdat  [2][8];
  logic [31:0] rdat  [2][8];

  int own[2];
  int wt[2];
  int MN[2] = '{4, 2};
  int SN[2] = '{8, 2};
  int SB[2] = '{3, 1};
  int TO[2] = '{15, 5};
  int n_chk  = 0;
  int n_fail = 0;

  always_comb begin
    ifa.m_req_ = req_n[0][3:0];
    ifa.m_as_  = as_n[0][3:0];
    ifa.m_rw   = rw[0][3:0];
    ifa.s_rdy_ = srdy_n[0];
    ifa.m_addr = '0;
    ifa.m_w_data = '0;
    ifa.s_r_data = '0;
    for (int i = 0; i < 4; i++) begin
      ifa.m_addr[i*30 +: 30]   = maddr[0][i];
      ifa.m_w_data[i*32 +: 32] = wdat[0][i];
    end
    for (int i = 0; i < 8; i++) ifa.s_r_data[i*32 +: 32] = rdat[0][i];
  end

  always_comb begin
    ifb.m_req_ = req_n[1][1:0];
    ifb.m_as_  = as_n[1][1:0];
    ifb.m_rw   = rw[1][1:0];
    ifb.s_rdy_ = srdy_n[1][1:0];
    ifb.m_addr = '0;
    ifb.m_w_data = '0;
    ifb.s_r_data = '0;
    for (int i = 0; i < 2; i++) begin
      ifb.m_addr[i*30 +: 30]   = maddr[1][i];
      ifb.m_w_data[i*32 +: 32] = wdat[1][i];
      ifb.s_r_data[i*32 +: 32] = rdat[1][i];
    end
  end

  task automatic check(string nm, int n, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, n, act, exp, $time);
    end
  endtask

  function automatic int sel_of(int n);
    return int'(maddr[n][own[n]] >> (30 - SB[n]));
  endfunction

  task automatic compare(int n);
    int s;
    bit tmo;
    logic [63:0] mm, ms;
    logic [63:0] a_grnt, a_addr, a_as, a_rw, a_wd, a_cs, a_rdy, a_rd, a_err, a_wait;
    s   = sel_of(n);
    tmo = (wt[n] == TO[n]) && (srdy_n[n][s] == 1'b1);
    mm  = (64'd1 << MN[n]) - 64'd1;
    ms  = (64'd1 << SN[n]) - 64'd1;
    if (n == 0) begin
      a_grnt = 64'(ifa.m_grnt_); a_addr = 64'(ifa.s_addr); a_as = 64'(ifa.s_as_);
      a_rw = 64'(ifa.s_rw); a_wd = 64'(ifa.s_w_data); a_cs = 64'(ifa.s_cs_);
      a_rdy = 64'(ifa.m_rdy_); a_rd = 64'(ifa.m_r_data); a_err = 64'(ifa.m_err);
      a_wait = 64'(ua.r_wait);
    end else begin
      a_grnt = 64'(ifb.m_grnt_); a_addr = 64'(ifb.s_addr); a_as = 64'(ifb.s_as_);
      a_rw = 64'(ifb.s_rw); a_wd = 64'(ifb.s_w_data); a_cs = 64'(ifb.s_cs_);
      a_rdy = 64'(ifb.m_rdy_); a_rd = 64'(ifb.m_r_data); a_err = 64'(ifb.m_err);
      a_wait = 64'(ub.r_wait);
    end
    check("grnt",   n, a_grnt, ~(64'd1 << own[n]) & mm);
    check("s_addr", n, a_addr, 64'(maddr[n][own[n]]));
    check("s_as",   n, a_as,   64'(as_n[n][own[n]]));
    check("s_rw",   n, a_rw,   64'(rw[n][own[n]]));
    check("s_wdat", n, a_wd,   64'(wdat[n][own[n]]));
    check("s_cs",   n, a_cs,   tmo ? ms : (~(64'd1 << s) & ms));
    check("m_rdy",  n, a_rdy,  tmo ? 64'd0 : 64'(srdy_n[n][s]));
    check("m_rdat", n, a_rd,   tmo ? 64'd0 : 64'(rdat[n][s]));
    check("m_err",  n, a_err,  64'(tmo));
    check("wait",   n, a_wait, 64'(wt[n]));
  endtask

  task automatic step_model(int n);
    int s, nxt, c;
    bit tmo, found;
    if (rst) begin
      own[n] = 0;
      wt[n]  = 0;
      return;
    end
    s   = sel_of(n);
    tmo = (wt[n] == TO[n]) && (srdy_n[n][s] == 1'b1);
    nxt = own[n];
    found = 1'b0;
    if (req_n[n][own[n]]) begin
      for (int i = 1; i < MN[n]; i++) begin
        c = (own[n] + i) % MN[n];
        if (!found && !req_n[n][c]) begin
          nxt = c;
          found = 1'b1;
        end
      end
    end
    if (nxt != own[n] || as_n[n][own[n]] || !srdy_n[n][s] || tmo) wt[n] = 0;
    else wt[n] = wt[n] + 1;
    own[n] = nxt;
  endtask

  task automatic rnd(int n);
    for (int i = 0; i < MN[n]; i++) begin
      if (!req_n[n][i]) begin
        if ($urandom_range(11) == 0) req_n[n][i] = 1'b1;
      end else if ($urandom_range(2) == 0) req_n[n][i] = 1'b0;
      if ($urandom_range(7) == 0) as_n[n][i] = ~as_n[n][i];
      if ($urandom_range(3) == 0) maddr[n][i] = 30'($urandom);
      rw[n][i]   = 1'($urandom);
      wdat[n][i] = $urandom;
    end
    for (int k = 0; k < SN[n]; k++) begin
      srdy_n[n][k] = ($urandom_range(9) != 0);
      rdat[n][k]   = $urandom;
    end
  endtask

  task automatic sample();
    rnd(1);
    #2;
    compare(0);
    compare(1);
  endtask

  task automatic advance();
    @(posedge clk);
    step_model(0);
    step_model(1);
    @(negedge clk);
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      req_n[n] = '1; as_n[n] = '1; rw[n] = '0; srdy_n[n] = '1;
      for (int i = 0; i < 8; i++) begin
        maddr[n][i] = '0; wdat[n][i] = '0; rdat[n][i] = '0;
      end
    end
    @(negedge clk);
    sample();
    check("rst_grnt", 0, 64'(ifa.m_grnt_), 64'h0E);
    check("rst_err",  0, 64'(ifa.m_err), 64'd0);
    check("rst_wait", 0, 64'(ua.r_wait), 64'd0);
    check("rst_grnt", 1, 64'(ifb.m_grnt_), 64'h2);
    advance();
    rst = 1'b0;

    // Arbitration: owner 0 holds, then releases with masters 1 and 3 waiting.
    req_n[0] = 8'hFE;
    sample(); advance();
    sample(); check("hold_grnt", 0, 64'(ifa.m_grnt_), 64'hE); advance();
    req_n[0] = 8'hF5;
    sample(); check("handoff_lat", 0, 64'(ifa.m_grnt_), 64'hE); advance();
    sample(); check("handoff_m1", 0, 64'(ifa.m_grnt_), 64'hD); advance();
    req_n[0] = 8'hF7;
    sample(); advance();
    sample(); check("handoff_m3", 0, 64'(ifa.m_grnt_), 64'h7); advance();

    // Read from slave 2 with three wait cycles.
    as_n[0][3] = 1'b0; rw[0][3] = 1'b1; maddr[0][3] = 30'h1000_0000;
    rdat[0][2] = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) srdy_n[0][2] = 1'b0;
      sample();
      if (k == 3) begin
        check("rd_rdy",  0, 64'(ifa.m_rdy_), 64'd0);
        check("rd_data", 0, 64'(ifa.m_r_data), 64'hDEAD_BEEF);
        check("rd_err",  0, 64'(ifa.m_err), 64'd0);
        check("rd_cs",   0, 64'(ifa.s_cs_), 64'hFB);
      end else check("rd_wait_rdy", 0, 64'(ifa.m_rdy_), 64'd1);
      advance();
    end
    srdy_n[0][2] = 1'b1; as_n[0][3] = 1'b1;
    sample(); advance();

    // Timeout on a silent slave.
    maddr[0][3] = 30'h3000_0000; as_n[0][3] = 1'b0;
    for (int k = 0; k < 17; k++) begin
      sample();
      if (k == 14) check("pre_to_err", 0, 64'(ifa.m_err), 64'd0);
      if (k == 15) begin
        check("to_err", 0, 64'(ifa.m_err), 64'd1);
        check("to_rdy", 0, 64'(ifa.m_rdy_), 64'd0);
        check("to_cs",  0, 64'(ifa.s_cs_), 64'hFF);
        check("to_dat", 0, 64'(ifa.m_r_data), 64'd0);
      end
      if (k == 16) begin
        check("post_to_err",  0, 64'(ifa.m_err), 64'd0);
        check("post_to_wait", 0, 64'(ua.r_wait), 64'd0);
      end
      advance();
    end
    as_n[0][3] = 1'b1;
    sample(); advance();

    // Slave ready in the timeout cycle wins.
    rdat[0][6] = 32'h1234_5678; as_n[0][3] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 15) srdy_n[0][6] = 1'b0;
      sample();
      if (k == 15) begin
        check("race_err", 0, 64'(ifa.m_err), 64'd0);
        check("race_rdy", 0, 64'(ifa.m_rdy_), 64'd0);
        check("race_dat", 0, 64'(ifa.m_r_data), 64'h1234_5678);
      end
      advance();
    end
    srdy_n[0][6] = 1'b1; as_n[0][3] = 1'b1;
    sample(); advance();

    // Reset in the middle of a wait with master 2 owning the bus.
    req_n[0] = 8'hFB;
    sample(); advance();
    sample(); check("own2_grnt", 0, 64'(ifa.m_grnt_), 64'hB);
    as_n[0][2] = 1'b0; maddr[0][2] = 30'h2000_0000;
    advance();
    for (int k = 0; k < 3; k++) begin sample(); advance(); end
    sample();
    rst = 1'b1;
    own[0] = 0; own[1] = 0; wt[0] = 0; wt[1] = 0;
    #1;
    check("mid_rst_grnt", 0, 64'(ifa.m_grnt_), 64'hE);
    check("mid_rst_wait", 0, 64'(ua.r_wait), 64'd0);
    check("mid_rst_err",  0, 64'(ifa.m_err), 64'd0);
    check("mid_rst_grnt", 1, 64'(ifb.m_grnt_), 64'h2);
    check("mid_rst_wait", 1, 64'(ub.r_wait), 64'd0);
    advance();
    sample(); advance();
    rst = 1'b0;
    sample(); check("rel_grnt", 0, 64'(ifa.m_grnt_), 64'hE); advance();
    sample(); check("rel_grnt2", 0, 64'(ifa.m_grnt_), 64'hB); advance();

    for (int c = 0; c < 3000; c++) begin
      rnd(0);
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
